// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial-side inputs and parallel-side outputs of the UART receiver.
// The master modport belongs to the line/tick driver; the slave modport belongs to the receiver.
interface uart_receiver_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 baud_tick;
   logic                 rx;
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output baud_tick,
      output rx,
      input  data,
      input  valid,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  baud_tick,
      input  rx,
      output data,
      output valid,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver driven by an external oversampling tick.
// Locks to the start-bit centre, samples each bit at its centre, emits one-clk valid or
// frame_err strobes. Define UART_RX_MAJORITY_EN to take each data/stop bit as the 2-of-3
// majority of the last three samples ending at the bit centre.
module uart_receiver #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   uart_receiver_if.slave bus
);

   localparam int unsigned TickW = $clog2(OVERSAMPLE);
   localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
   localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } state_e;

   logic                 rx_meta_q, rx_s_q;
   state_e               state_q, state_d;
   logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
   logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 bit_val;

   // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx;
         rx_s_q    <= rx_meta_q;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] early_q, early_d;

   // Capture the two samples preceding the bit centre for the majority vote.
   always_comb begin
      early_d = early_q;
      if (bus.baud_tick) begin
         if (tick_cnt_q == TickLast - TickW'(2)) early_d[0] = rx_s_q;
         if (tick_cnt_q == TickLast - TickW'(1)) early_d[1] = rx_s_q;
      end
   end

   // Early-sample registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) early_q <= 2'b11;
      else         early_q <= early_d;
   end

   assign bit_val = (early_q[0] & early_q[1]) | (early_q[0] & rx_s_q) | (early_q[1] & rx_s_q);
`else
   assign bit_val = rx_s_q;
`endif

   // Next-state and strobe logic; everything advances only on baud ticks.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      if (bus.baud_tick) begin
         unique case (state_q)
            StIdle: begin
               if (!rx_s_q) begin
                  state_d    = StStart;
                  tick_cnt_d = '0;
               end
            end
            StStart: begin
               if (tick_cnt_q == TickHalf) begin
                  // Still low at mid start bit: genuine start, otherwise a glitch.
                  if (!rx_s_q) begin
                     state_d    = StData;
                     tick_cnt_d = '0;
                     bit_cnt_d  = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TickW'(1);
               end
            end
            StData: begin
               if (tick_cnt_q == TickLast) begin
                  tick_cnt_d = '0;
                  shift_d    = {bit_val, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == BitLast) state_d = StStop;
                  else                      bit_cnt_d = bit_cnt_q + BitW'(1);
               end else begin
                  tick_cnt_d = tick_cnt_q + TickW'(1);
               end
            end
            StStop: begin
               if (tick_cnt_q == TickLast) begin
                  tick_cnt_d = '0;
                  if (bit_val) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                     state_d = StIdle;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = StWaitHigh;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TickW'(1);
               end
            end
            StWaitHigh: begin
               // Stay here through a break so a held-low line yields no further frames.
               if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q != StIdle);

endmodule
